// File: rtl/tetris_pkg.sv
// Shared types and constants for the 8x8 LED Tetris playfield logic.
// Rows are indexed [y][x], with row 0 at the top and row 7 at the bottom.
package tetris_pkg;

  typedef logic [7:0][7:0] matrix_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MERGE,
    ST_SCAN,
    ST_SHIFT,
    ST_DONE,
    ST_OVER
  } pf_state_t;

  localparam logic [7:0] FULL_ROW = 8'hFF;
  localparam int         ROWS     = 8;

  // Three-bit counter increment that sticks at 7.
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? 3'd7 : v + 3'd1;
  endfunction

endpackage

// File: rtl/field_row_shifter.sv
// Combinational gravity collapse: removes row `row` and drops every row above it by one.
// Row 0 is refilled with zeros.
module field_row_shifter
  import tetris_pkg::*;
(
  input  matrix_t    field,
  input  logic [2:0] row,
  output matrix_t    shifted
);

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      if (gi == 0) begin : g_top
        assign shifted[gi] = '0;
      end else begin : g_body
        localparam logic [2:0] ROW_IDX = 3'(gi);
        assign shifted[gi] = (ROW_IDX <= row) ? field[gi-1] : field[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/playfield_manager.sv
// Fixed playfield owner: merges locked pieces, clears full rows with collapse,
// tracks cleared lines and game over, and builds the composite display frame.
module playfield_manager
  import tetris_pkg::*;
#(
  parameter int LINE_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lockReq,
  input  matrix_t               pieceIn,
  input  logic                  pieceValid,
  output matrix_t               matrixOut,
  output matrix_t               displayOut,
  output logic                  busy,
  output logic                  lockDone,
  output logic [2:0]            clearedCount,
  output logic [LINE_CNT_W-1:0] totalLines,
  output logic                  gameOver
);

  pf_state_t             state_reg,     state_next;
  matrix_t               field_reg,     field_next;
  matrix_t               latched_reg,   latched_next;
  logic [2:0]            row_reg,       row_next;
  logic [2:0]            cleared_reg,   cleared_next;
  logic [LINE_CNT_W-1:0] total_reg,     total_next;
  logic                  game_over_reg, game_over_next;

  matrix_t               shifted;
  logic [LINE_CNT_W:0]   total_sum;

  field_row_shifter u_shifter (
    .field   (field_reg),
    .row     (row_reg),
    .shifted (shifted)
  );

  // Extra carry bit detects overflow so the line counter saturates.
  assign total_sum = {1'b0, total_reg} + (LINE_CNT_W+1)'(cleared_reg);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      field_reg     <= '0;
      latched_reg   <= '0;
      row_reg       <= '0;
      cleared_reg   <= '0;
      total_reg     <= '0;
      game_over_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      field_reg     <= field_next;
      latched_reg   <= latched_next;
      row_reg       <= row_next;
      cleared_reg   <= cleared_next;
      total_reg     <= total_next;
      game_over_reg <= game_over_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    field_next     = field_reg;
    latched_next   = latched_reg;
    row_next       = row_reg;
    cleared_next   = cleared_reg;
    total_next     = total_reg;
    game_over_next = game_over_reg;

    case (state_reg)
      ST_IDLE: begin
        if (lockReq) begin
          latched_next = pieceIn;
          state_next   = ST_MERGE;
        end
      end
      ST_MERGE: begin
        field_next = field_reg | latched_reg;
        if ((field_reg & latched_reg) != '0) begin
          game_over_next = 1'b1;
          state_next     = ST_OVER;
        end else begin
          row_next     = 3'd7;
          cleared_next = 3'd0;
          state_next   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (field_reg[row_reg] == FULL_ROW) begin
          state_next = ST_SHIFT;
        end else if (row_reg == 3'd0) begin
          state_next = ST_DONE;
        end else begin
          row_next = row_reg - 3'd1;
        end
      end
      ST_SHIFT: begin
        // Row index is kept so the row that fell into place is scanned again.
        field_next   = shifted;
        cleared_next = sat_inc3(cleared_reg);
        state_next   = ST_SCAN;
      end
      ST_DONE: begin
        total_next = total_sum[LINE_CNT_W] ? '1 : total_sum[LINE_CNT_W-1:0];
        state_next = ST_IDLE;
      end
      ST_OVER: begin
        state_next = ST_OVER;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy         = (state_reg == ST_MERGE) || (state_reg == ST_SCAN) ||
                        (state_reg == ST_SHIFT) || (state_reg == ST_DONE);
  assign lockDone     = (state_reg == ST_DONE);
  assign matrixOut    = field_reg;
  assign clearedCount = cleared_reg;
  assign totalLines   = total_reg;
  assign gameOver     = game_over_reg;
  assign displayOut   = field_reg | ((pieceValid && !busy) ? pieceIn : '0);

endmodule

// File: tb/tb_playfield_manager.sv
// Randomized bench for playfield_manager against a row-compaction reference model.
module tb_playfield_manager;
  import tetris_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       lockReq = 1'b0;
  logic       pieceValid = 1'b0;
  matrix_t    pieceIn = '0;
  matrix_t    matrixOut, displayOut;
  logic       busy, lockDone, gameOver;
  logic [2:0] clearedCount;
  logic [7:0] totalLines;

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;

  matrix_t model_field;
  int      model_total;

  playfield_manager #(.LINE_CNT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .lockReq      (lockReq),
    .pieceIn      (pieceIn),
    .pieceValid   (pieceValid),
    .matrixOut    (matrixOut),
    .displayOut   (displayOut),
    .busy         (busy),
    .lockDone     (lockDone),
    .clearedCount (clearedCount),
    .totalLines   (totalLines),
    .gameOver     (gameOver)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (lockDone === 1'b1) done_pulses++;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic matrix_t mk(input int y, input logic [7:0] v);
    matrix_t m = '0;
    m[y] = v;
    return m;
  endfunction

  // Reference clear: keep non-full rows in order and pack them to the bottom.
  function automatic void clear_model(input matrix_t m, output matrix_t res, output int n);
    int dst = 7;
    res = '0;
    n = 0;
    for (int src = 7; src >= 0; src--) begin
      if (m[src] == 8'hFF) n++;
      else begin
        res[dst] = m[src];
        dst--;
      end
    end
  endfunction

  function automatic matrix_t rand_piece(input matrix_t f);
    matrix_t p = '0;
    for (int y = 0; y < 8; y++) begin
      int ch = $urandom_range(0, 5);
      if (ch == 0) p[y] = ~f[y];
      else if (ch <= 2) p[y] = 8'($urandom) & ~f[y];
    end
    return p;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    lockReq = 1'b0;
    repeat (2) tick();
    check("rst_matrix", matrixOut, 64'd0);
    check("rst_flags", {busy, lockDone, gameOver}, 3'b000);
    check("rst_counts", {clearedCount, totalLines}, 11'd0);
    reset = 1'b1;
    model_field = '0;
    model_total = 0;
    $display("reset: field cleared");
  endtask

  task automatic do_lock(input matrix_t piece);
    matrix_t merged, expf;
    int n, cl, c, start_pulses;
    bit overlap;
    overlap = (model_field & piece) != '0;
    merged  = model_field | piece;
    pieceIn = piece;
    pieceValid = 1'b1;
    lockReq = 1'b1;
    #1;
    check("disp_idle", displayOut, model_field | piece);
    start_pulses = done_pulses;
    tick();                                  // cycle 1 (MERGE)
    lockReq = 1'b0;
    pieceIn = {$urandom, $urandom};          // must not affect the lock
    #1;
    check("busy_merge", busy, 1'b1);
    check("disp_busy", displayOut, model_field);
    tick();                                  // cycle 2
    check("merge_field", matrixOut, merged);
    if (overlap) begin
      check("over_flag", {gameOver, busy}, 2'b10);
      for (int k = 0; k < 20; k++) begin
        tick();
        lockReq = (k == 3);
        if (k == 3) pieceIn = rand_piece('0);
      end
      check("over_nodone", done_pulses - start_pulses, 0);
      check("over_frozen", matrixOut, merged);
      check("over_sticky", {gameOver, busy}, 2'b10);
      model_field = merged;
      $display("lock piece=%h overlap -> gameOver field=%h", piece, merged);
      return;
    end
    check("no_over", gameOver, 1'b0);
    clear_model(merged, expf, n);
    cl = (n > 7) ? 7 : n;
    c = 2;
    while (lockDone !== 1'b1 && c < 80) begin
      tick();
      c++;
      lockReq = (c == 4);                    // ignored request during SCAN
      if (c == 4) pieceIn = rand_piece('0);
    end
    lockReq = 1'b0;
    check("done_cycle", c, 10 + 2 * n);
    check("done_field", matrixOut, expf);
    check("done_cleared", clearedCount, cl);
    model_field = expf;
    model_total = (model_total + cl > 255) ? 255 : model_total + cl;
    tick();
    check("idle_flags", {busy, lockDone}, 2'b00);
    check("total_lines", totalLines, model_total);
    repeat (3) tick();
    check("one_done", done_pulses - start_pulses, 1);
    $display("lock piece=%h cleared=%0d cycles=%0d field=%h total=%0d",
             piece, n, c, expf, model_total);
  endtask

  initial begin
    do_reset();

    // no clear: O piece at bottom
    do_lock(mk(6, 8'h03) | mk(7, 8'h03));
    check("o_piece", matrixOut, mk(6, 8'h03) | mk(7, 8'h03));

    // single clear
    do_reset();
    do_lock(mk(7, 8'hF0));
    do_lock(mk(6, 8'h01));
    do_lock(mk(7, 8'h0F));
    check("single_clear", {matrixOut, clearedCount, totalLines}, {mk(7, 8'h01), 3'd1, 8'd1});

    // non-adjacent double clear
    do_reset();
    do_lock(mk(7, 8'hFE) | mk(6, 8'h3C) | mk(5, 8'h7F));
    do_lock(mk(7, 8'h01) | mk(5, 8'h80));
    check("double_clear", {matrixOut, clearedCount, totalLines}, {mk(7, 8'h3C), 3'd2, 8'd2});

    // game over
    do_reset();
    do_lock(mk(0, 8'h18));
    do_lock(mk(0, 8'h08));
    check("go_row0", matrixOut, mk(0, 8'h18));

    // reset asserted during SHIFT
    do_reset();
    pieceIn = mk(7, 8'hFF);
    lockReq = 1'b1;
    tick();                                  // cycle 1
    lockReq = 1'b0;
    tick();                                  // cycle 2: SCAN row 7
    tick();                                  // cycle 3: SHIFT
    check("shift_busy", busy, 1'b1);
    reset = 1'b0;
    tick();
    check("midrst_matrix", matrixOut, 64'd0);
    check("midrst_flags", {busy, lockDone, gameOver, clearedCount, totalLines}, 14'd0);
    reset = 1'b1;
    model_field = '0;
    model_total = 0;
    $display("reset during SHIFT: field cleared");

    // randomized games, each ending in an overlap
    for (int g = 0; g < 6; g++) begin
      do_reset();
      for (int k = 0; k < 10; k++) do_lock(rand_piece(model_field));
      if (model_field == '0) do_lock(mk($urandom_range(0, 7), 8'h10));
      do_lock(model_field | matrix_t'({$urandom, $urandom}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/playfield_manager.md
# playfield_manager

Owns the fixed playfield of the 8x8 LED Tetris. It receives the active piece matrix from the tetrimino driver and merges it into the field on a lock request. It then clears full rows with gravity collapse and returns the fixed field to the driver as its `matrixIn`. It also produces the composite frame sent to the LED display path.

## Interface
Parameters:
- `LINE_CNT_W`, default 8: width of the running cleared-line counter.

Ports:
- `clk`  in  1: system clock; all logic is on its rising edge.
- `reset`  in  1: synchronous, active-low. `reset==0` at a rising edge initialises the block.
- `lockReq`  in  1: request to merge `pieceIn` into the field. Sampled only in IDLE.
- `pieceIn`  in  [7:0][7:0]: active-piece matrix. `[y][x]`, row 0 = top, row 7 = bottom.
- `pieceValid`  in  1: driver's enableDisplay. Gates `pieceIn` onto `displayOut`.
- `matrixOut`  out  [7:0][7:0]: registered fixed field. Feeds the driver's `matrixIn`.
- `displayOut`  out  [7:0][7:0]: combinational `matrixOut | (pieceValid && !busy ? pieceIn : 0)`.
- `busy`  out  1: high in MERGE, SCAN, SHIFT, DONE.
- `lockDone`  out  1: one-cycle pulse when a lock completes.
- `clearedCount`  out  3: rows cleared by the last lock. Valid while `lockDone` is high, held until the next MERGE.
- `totalLines`  out  LINE_CNT_W: lines cleared since reset. Saturates at all-ones.
- `gameOver`  out  1: sticky. Cleared only by reset.

## Operation
States: IDLE, MERGE, SCAN, SHIFT, DONE, OVER.
- **IDLE:** on `lockReq==1`, latch `pieceIn` and go to MERGE. `lockReq` while busy or in OVER is ignored; there is no queue.
- **MERGE:**
  - If `(field & latched) != 0`: set `field |= latched`, set `gameOver=1`, go to OVER.
  - Otherwise: set `field |= latched`, `r=7`, `clearedCount=0`, go to SCAN.
- **SCAN (row r):**
  - If `field[r]==8'hFF`, go to SHIFT.
  - Else if `r==0`, go to DONE.
  - Else decrement `r` and stay in SCAN.
- **SHIFT:**
  - `field[i] <= field[i-1]` for `i=r..1`.
  - `field[0] <= 0`.
  - `clearedCount++` (saturating at 7).
  - Return to SCAN with `r` unchanged, so the collapsed row is re-examined.
- **DONE:** `lockDone=1`, `totalLines += clearedCount` (saturating), go to IDLE.
- **OVER:** terminal. `busy=0`, `lockDone` is never pulsed, `matrixOut` is frozen.
- Invariant: no full row exists outside a lock, so `clearedCount` never exceeds 4 in normal play. The saturation is defensive.

## Timing
- Reset values:
  - `matrixOut`, `clearedCount`, `totalLines`: 0.
  - `busy`, `lockDone`, `gameOver`: 0.
  - State: IDLE.
- Reset mid-operation (any state, including SHIFT and OVER) takes effect at the same edge. The next cycle is IDLE with an empty field.
- Let cycle 0 be the IDLE cycle with `lockReq` high:
  - Cycle 1 is MERGE.
  - Cycles 2..9 are SCAN of rows 7..0 when nothing clears.
  - Cycle 10 is DONE (`lockDone` high).
  - Each cleared row adds 2 cycles (SHIFT plus the re-scan).
- `matrixOut` reflects the merge from cycle 2 and each collapse from the cycle after its SHIFT.
- `pieceIn` is sampled only at the cycle-0 edge. Later changes have no effect.
- On overlap, `gameOver` is high from cycle 2.

## Structure
- Package `tetris_pkg`:
  - `typedef logic [7:0][7:0] matrix_t`
  - state enum `pf_state_t`
  - constants `FULL_ROW = 8'hFF` and `ROWS = 8`
- Sub-module `field_row_shifter`: combinational. Inputs are a `matrix_t` and a row index `r`. Output is the field with row `r` removed, rows above shifted down, and row 0 zeroed. It is instantiated once and used in SHIFT.

## Test plan
1. Reset: drive `reset=0` for 2 cycles -> all outputs 0 and state IDLE. Repeat with `reset=0` asserted during SHIFT -> same result the next cycle.
2. No clear: empty field; lock O piece with rows 6 and 7 = 8'h03 -> `lockDone` at cycle 10, `matrixOut` rows 6 and 7 = 8'h03, `clearedCount=0`, `totalLines=0`.
3. Single clear: build row7=8'hF0 and row6=8'h01 by prior locks; lock row7=8'h0F -> `lockDone` at cycle 12, row7=8'h01, row6=8'h00, `clearedCount=1`, `totalLines=1`.
4. Non-adjacent double clear: after merge, rows 7 and 5 = 8'hFF and row6=8'h3C -> `lockDone` at cycle 14, row7=8'h3C, rows 0..6 = 0, `clearedCount=2`, `totalLines` up by 2.
5. Game over: field row0=8'h18; lock row0=8'h08 -> `gameOver=1` at cycle 2 and `matrixOut` row0=8'h18. No `lockDone` follows. A later `lockReq` changes nothing.
6. Busy and display: pulse `lockReq` again during SCAN -> ignored, exactly one `lockDone`. With `pieceValid=1` in IDLE, `displayOut == matrixOut | pieceIn`. While busy, `displayOut == matrixOut`.
